// File: rtl/load_buffer.sv
// Load buffer: queues dispatched loads in order, issues one memory read at a
// time, sign/zero-extends the returned data by func3 and writes it back to the
// instruction queue. Branch-mispredict clear flushes the queue; IO-space loads
// wait until they are the oldest instruction in the IQ.
module load_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned IQ_ADDR_W = 4,
   parameter logic [31:0] IO_BASE   = 32'h00030000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clear_flag_in,
   input  logic                 rs_load_enable_in,
   input  logic [2:0]           rs_func3_in,
   input  logic [31:0]          rs_addr_in,
   input  logic [IQ_ADDR_W-1:0] rs_pos_in_iq_in,
   output logic                 lb_full_out,
   input  logic [IQ_ADDR_W-1:0] iq_head_in,
   output logic                 mem_valid_out,
   output logic [31:0]          mem_addr_out,
   output logic [1:0]           mem_len_out,
   input  logic                 mem_done_in,
   input  logic [31:0]          mem_data_in,
   output logic                 iq_write_enable_out,
   output logic [IQ_ADDR_W-1:0] iq_write_idx_out,
   output logic [31:0]          iq_write_result_out
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_e;

   typedef struct packed {
      logic [2:0]           func3;
      logic [31:0]          addr;
      logic [IQ_ADDR_W-1:0] pos;
   } entry_t;

   entry_t               ent_q [DEPTH];
   entry_t               ent_d [DEPTH];
   state_e               state_q, state_d;
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 mem_valid_q, mem_valid_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [1:0]           mem_len_q, mem_len_d;
   logic [IQ_ADDR_W-1:0] iq_idx_q, iq_idx_d;
   logic [31:0]          iq_res_q, iq_res_d;

   entry_t head_ent;
   logic   head_may_issue;
   logic   push;
   logic   pop;

   // Sign/zero extension of right-justified read data by load type.
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0:    return {{24{d[7]}}, d[7:0]};
         3'd1:    return {{16{d[15]}}, d[15:0]};
         3'd4:    return {24'b0, d[7:0]};
         3'd5:    return {16'b0, d[15:0]};
         default: return d;
      endcase
   endfunction

   assign head_ent       = ent_q[head_q];
   assign head_may_issue = (head_ent.addr < IO_BASE) || (head_ent.pos == iq_head_in);

   // Full one entry early so a load already in the RS dispatch register still fits.
   assign lb_full_out         = (count_q >= FULL_LVL);
   assign mem_valid_out       = mem_valid_q;
   assign mem_addr_out        = mem_addr_q;
   assign mem_len_out         = mem_len_q;
   assign iq_write_idx_out    = iq_idx_q;
   assign iq_write_result_out = iq_res_q;
   // The write commits only in a RESP cycle with rdy high, so it is a single pulse;
   // clear or reset in that cycle suppresses it.
   assign iq_write_enable_out = (state_q == RESP) && rdy && !clear_flag_in && !rst;

   // Next-state logic: FSM, queue pointers and registered memory/IQ outputs.
   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      ent_d       = ent_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_len_d   = mem_len_q;
      iq_idx_d    = iq_idx_q;
      iq_res_d    = iq_res_q;
      pop         = 1'b0;
      push        = rs_load_enable_in && !clear_flag_in && (count_q != DEPTH_C);

      // An in-flight read always completes (its done is captured even with rdy low);
      // only starting a new read waits for rdy.
      case (state_q)
         IDLE: begin
            if (rdy && (count_q != '0) && head_may_issue) begin
               state_d     = REQ;
               mem_valid_d = 1'b1;
               mem_addr_d  = head_ent.addr;
               mem_len_d   = head_ent.func3[1:0];
            end
         end
         REQ: begin
            if (mem_done_in) begin
               state_d     = RESP;
               mem_valid_d = 1'b0;
               iq_idx_d    = head_ent.pos;
               iq_res_d    = extend_load(head_ent.func3, mem_data_in);
            end
         end
         RESP: begin
            if (rdy) begin
               pop     = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (mem_done_in) begin
               state_d     = IDLE;
               mem_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         ent_d[tail_q] = '{func3: rs_func3_in, addr: rs_addr_in, pos: rs_pos_in_iq_in};
         tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // Flush: the memory controller cannot abort, so an unfinished read is drained.
      if (clear_flag_in) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         iq_idx_d = iq_idx_q;
         iq_res_d = iq_res_q;
         if (((state_q == REQ) || (state_q == DRAIN)) && !mem_done_in) begin
            state_d     = DRAIN;
            mem_valid_d = 1'b1;
         end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
         end
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_len_q   <= '0;
         iq_idx_q    <= '0;
         iq_res_q    <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_len_q   <= mem_len_d;
         iq_idx_q    <= iq_idx_d;
         iq_res_q    <= iq_res_d;
      end
   end

   // Entry storage; contents are only meaningful between head and tail.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

endmodule
